// File: rtl/uart_cmd_mstr.sv
// -----------------------------------------------------------------------------
// uart_cmd_mstr
//   Host-side UART command master. It sends a CMD_BYTES-wide command MSB-first
//   through a byte transmitter (trmt/tx_done) and collects the response through
//   a byte receiver (rx_rdy/clr_rx_rdy). A command whose opcode (top byte)
//   equals DUMP_OP expects DUMP_LEN response bytes. Any other command expects
//   a single byte.
//
//   Optional build macro: ACK_CHK_EN. When it is defined, a single-byte
//   response that differs from ACK_VAL sets the sticky nak flag. Otherwise
//   nak is tied low.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd          : command word, opcode in the top byte
//   send_cmd     : start request, honoured only while idle
//   busy         : transaction in progress
//   cmd_sent     : pulse when the last command byte has been transmitted
//   tx_data/trmt : byte and one-cycle strobe to the transmitter
//   tx_done      : transmitter byte complete (its rising edge is used)
//   rx_data/rx_rdy/clr_rx_rdy : receiver byte, valid level and clear pulse
//   resp/resp_vld: last response byte and its one-cycle valid pulse
//   resp_cnt     : response bytes collected in this transaction
//   resp_done    : pulse when all expected bytes have arrived
//   tmo          : sticky timeout flag
//   nak          : sticky bad-acknowledge flag
// -----------------------------------------------------------------------------
module uart_cmd_mstr #(
    parameter int          CMD_BYTES = 3,
    parameter int          DUMP_LEN  = 510,
    parameter logic [7:0]  DUMP_OP   = 8'h01,
    parameter int          TMO_CYC   = 200000,
    parameter logic [7:0]  ACK_VAL   = 8'hA5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [8*CMD_BYTES-1:0]            cmd,
    input  logic                              send_cmd,
    output logic                              busy,
    output logic                              cmd_sent,
    output logic [7:0]                        tx_data,
    output logic                              trmt,
    input  logic                              tx_done,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_rdy,
    output logic                              clr_rx_rdy,
    output logic [7:0]                        resp,
    output logic                              resp_vld,
    output logic [$clog2(DUMP_LEN+1)-1:0]     resp_cnt,
    output logic                              resp_done,
    output logic                              tmo,
    output logic                              nak
);

    localparam int CNT_W = $clog2(DUMP_LEN + 1);
    localparam int IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] STRB    = 3'd2;
    localparam logic [2:0] WAIT_TX = 3'd3;
    localparam logic [2:0] WAIT_RX = 3'd4;
    localparam logic [2:0] CLR     = 3'd5;

    logic [2:0]             state_r;
    logic [8*CMD_BYTES-1:0] shadow_r;
    logic [IDX_W-1:0]       idx_r;
    logic [CNT_W-1:0]       exp_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic                   tx_done_d_r;

    logic                   tx_rise_s;
    logic                   tmo_hit_s;
    logic                   op_dump_s;
    logic [7:0]             byte_s;

    // Edge detect, timeout terminal count, opcode decode and byte select.
    always_comb begin
        tx_rise_s = tx_done & ~tx_done_d_r;
        tmo_hit_s = (tmo_cnt_r == TMO_W'(TMO_CYC - 1));
        op_dump_s = (shadow_r[8*CMD_BYTES-1 -: 8] == DUMP_OP);
        byte_s    = shadow_r[8*int'(idx_r) +: 8];
    end

    // Transaction sequencer: command serialisation, response collection, timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shadow_r    <= {(8*CMD_BYTES){1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            exp_r       <= {CNT_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            tx_done_d_r <= 1'b0;
            busy        <= 1'b0;
            cmd_sent    <= 1'b0;
            tx_data     <= 8'h00;
            trmt        <= 1'b0;
            clr_rx_rdy  <= 1'b0;
            resp        <= 8'h00;
            resp_vld    <= 1'b0;
            resp_cnt    <= {CNT_W{1'b0}};
            resp_done   <= 1'b0;
            tmo         <= 1'b0;
`ifdef ACK_CHK_EN
            nak         <= 1'b0;
`endif
        end else begin
            tx_done_d_r <= tx_done;
            trmt        <= 1'b0;
            cmd_sent    <= 1'b0;
            clr_rx_rdy  <= 1'b0;
            resp_vld    <= 1'b0;
            resp_done   <= 1'b0;
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                    if (send_cmd) begin
                        shadow_r <= cmd;
                        tmo      <= 1'b0;
`ifdef ACK_CHK_EN
                        nak      <= 1'b0;
`endif
                        resp_cnt <= {CNT_W{1'b0}};
                        busy     <= 1'b1;
                        idx_r    <= IDX_W'(CMD_BYTES - 1);
                        state_r  <= LOAD;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                LOAD: begin
                    // trmt is registered here so it is high exactly while in STRB.
                    tx_data   <= byte_s;
                    trmt      <= 1'b1;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                    state_r   <= STRB;
                end
                STRB: begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                    state_r   <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_rise_s) begin
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        if (idx_r != {IDX_W{1'b0}}) begin
                            idx_r   <= idx_r - IDX_W'(1);
                            state_r <= LOAD;
                        end else begin
                            cmd_sent <= 1'b1;
                            exp_r    <= op_dump_s ? CNT_W'(DUMP_LEN) : CNT_W'(1);
                            state_r  <= WAIT_RX;
                        end
                    end else if (tmo_hit_s) begin
                        tmo        <= 1'b1;
                        clr_rx_rdy <= 1'b1;
                        busy       <= 1'b0;
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                WAIT_RX: begin
                    if (rx_rdy) begin
                        resp       <= rx_data;
                        resp_vld   <= 1'b1;
                        clr_rx_rdy <= 1'b1;
                        // Saturate so a stray byte can never wrap the count.
                        resp_cnt   <= (resp_cnt == exp_r) ? resp_cnt : resp_cnt + CNT_W'(1);
`ifdef ACK_CHK_EN
                        if (!op_dump_s && (rx_data != ACK_VAL)) begin
                            nak <= 1'b1;
                        end else begin
                            nak <= nak;
                        end
`endif
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                        state_r    <= CLR;
                    end else if (tmo_hit_s) begin
                        tmo        <= 1'b1;
                        clr_rx_rdy <= 1'b1;
                        busy       <= 1'b0;
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                CLR: begin
                    // One idle cycle so the receiver can drop rx_rdy after the clear.
                    tmo_cnt_r <= {TMO_W{1'b0}};
                    if (resp_cnt == exp_r) begin
                        resp_done <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= WAIT_RX;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifndef ACK_CHK_EN
    assign nak = 1'b0;
`endif

endmodule

// File: doc/uart_cmd_mstr.md
Name: uart_cmd_mstr

Overview:
Host-side UART command master: the synthesizable, parametrised successor to the bench's 3-byte send task. It serializes a CMD_BYTES-wide command MSB-first through a byte UART transmitter (trmt/tx_done) and collects the response through a byte receiver (rx_rdy/clr_rx_rdy). A non-dump command expects a 1-byte response; a dump command expects DUMP_LEN bytes. Used as the host model in DSO_dig system benches and as an on-FPGA self-test host.

Parameters:
CMD_BYTES, 3, command length in bytes (≥1); the opcode is the top byte.
DUMP_LEN, 510, bytes expected after a dump opcode (≥1).
DUMP_OP, 8'h01, opcode value that selects multi-byte response collection.
TMO_CYC, 200000, max clk cycles allowed with no byte progress before abort.
ACK_VAL, 8'hA5, expected positive acknowledge (used by the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd  in  8*CMD_BYTES  command word; byte CMD_BYTES-1 is the opcode
send_cmd  in  1  one-cycle start request; sampled only in IDLE
busy  out  1  high from accept until return to IDLE
cmd_sent  out  1  one-cycle pulse when the last command byte's tx_done arrives
tx_data  out  8  byte to the UART transmitter
trmt  out  1  one-cycle transmit strobe
tx_done  in  1  transmitter finished the current byte (level or pulse; rising edge used)
rx_data  in  8  received byte
rx_rdy  in  1  received byte valid (held until cleared)
clr_rx_rdy  out  1  one-cycle clear to the receiver
resp  out  8  last response byte
resp_vld  out  1  one-cycle pulse per response byte
resp_cnt  out  clog2(DUMP_LEN+1)  response bytes collected in the current transaction
resp_done  out  1  one-cycle pulse when all expected bytes have arrived
tmo  out  1  sticky timeout flag; cleared by the next accepted send_cmd
nak  out  1  sticky bad-ack flag (optional feature); cleared by the next accepted send_cmd

Behaviour:
- Reset: state IDLE; busy, cmd_sent, trmt, clr_rx_rdy, resp_vld, resp_done, tmo, nak = 0; tx_data, resp = 8'h00; resp_cnt = 0; byte index = 0.
- States: IDLE, LOAD, STRB, WAIT_TX, WAIT_RX, CLR.
- IDLE: send_cmd=1 latches cmd into a shadow register, clears tmo, nak and resp_cnt, sets busy, and sets byte index = CMD_BYTES-1. Next state LOAD.
- LOAD: tx_data <= shadow byte[index]. Next state STRB.
- STRB: trmt=1 for exactly one cycle. Next state WAIT_TX. tx_data stays stable until the next LOAD.
- WAIT_TX: on a tx_done rising edge, if index≠0 then decrement index and go to LOAD. Otherwise pulse cmd_sent, set expected = (opcode==DUMP_OP) ? DUMP_LEN : 1, and go to WAIT_RX. Inter-byte gap is 2 cycles after tx_done.
- WAIT_RX: rx_rdy=1 captures resp<=rx_data, pulses resp_vld and clr_rx_rdy in the same cycle, increments resp_cnt, then goes to CLR.
- CLR: one cycle to let rx_rdy drop. If resp_cnt==expected, pulse resp_done, drop busy and return to IDLE; else return to WAIT_RX.
- Response latency: resp_vld fires 1 cycle after rx_rdy is seen.
- Timeout: a counter resets on entry to every state and on each tx_done/rx_rdy event. It counts in WAIT_TX and WAIT_RX. Reaching TMO_CYC-1 sets tmo, pulses clr_rx_rdy, drops busy and returns to IDLE with no resp_done.
- send_cmd while busy is ignored: no queueing, no effect on the shadow register.
- rx_rdy already high on entry to WAIT_RX is consumed as the first response byte.
- rx_rdy during WAIT_TX or STRB is not consumed there; it is held for WAIT_RX.
- Asynchronous reset mid-transaction returns all outputs to reset values immediately; the partial command is abandoned.
- resp_cnt saturates at expected and never wraps.

Optional Feature:
Macro ACK_CHK_EN. When defined, for a non-dump command whose single response byte ≠ ACK_VAL, nak is set in the same cycle as resp_vld and stays set until the next accepted send_cmd. When not defined, nak is tied to 0 and the compare logic is removed. The port exists in both builds.

Test Plan:
- Reset with rst_n=0 → all outputs 0, busy=0; send_cmd is ignored while rst_n=0.
- cmd=24'h082ABB, send_cmd pulse → trmt pulses ×3 with tx_data 08, 2A, BB in order; cmd_sent once; receiver returns A5 → resp=A5, resp_cnt=1, resp_done pulse, nak=0.
- cmd=24'h0100FF (dump), receiver model returns 510 bytes 00..FD (mod 256) → 510 resp_vld pulses in order, 510 clr_rx_rdy pulses, resp_cnt=510, resp_done once.
- cmd=24'h09_2A_FF with the receiver silent, TMO_CYC=1000 → tmo=1 about 1000 cycles after cmd_sent, busy=0, resp_done never pulses; the next send_cmd clears tmo.
- send_cmd re-asserted mid-transmission with a different cmd → tx_data sequence is unchanged; only one transaction runs.
- ACK_CHK_EN defined, cmd=24'h030080, response EE → nak=1, resp=EE; next command answered with A5 → nak clears on accept and stays 0.
